// File: rtl/key_expansion.sv
// key_expansion: one AES-128 key-schedule round (RotWord/SubWord/Rcon/chaining), registered output.
// Optional macro KEYEXP_INREG_EN adds a reset-to-zero input register (latency 2 instead of 1).
module key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:3]   keyInit,
  input  logic [0:127] key,
  output logic [0:127] roundKey
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Padded to 16 entries so any 4-bit index selects in range; only 1..10 are used.
  localparam logic [0:127] RCON = 128'h01020408102040801b36000000000000;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  logic [3:0]   idx_in;
  logic [0:127] key_in;

`ifdef KEYEXP_INREG_EN
  logic [3:0]   idx_d, idx_q;
  logic [0:127] key_d, key_q;

  always_comb begin
    idx_d = keyInit;
    key_d = key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      key_q <= '0;
    end else begin
      idx_q <= idx_d;
      key_q <= key_d;
    end
  end

  always_comb begin
    idx_in = idx_q;
    key_in = key_q;
  end
`else
  always_comb begin
    idx_in = keyInit;
    key_in = key;
  end
`endif

  logic [31:0]  w [4];
  logic [31:0]  n [4];
  logic [31:0]  t;
  logic [7:0]   rc;
  logic [0:127] round_key_d, round_key_q;

  always_comb begin
    // Words are columns of the row-major matrix; word bits [31:24] are row 0.
    for (int unsigned c = 0; c < 4; c++) begin
      w[c] = {key_in[8*c +: 8], key_in[32+8*c +: 8], key_in[64+8*c +: 8], key_in[96+8*c +: 8]};
    end
    rc = RCON[{idx_in - 4'd1, 3'b000} +: 8];
    t  = {sub_byte(w[3][23:16]), sub_byte(w[3][15:8]), sub_byte(w[3][7:0]), sub_byte(w[3][31:24])}
         ^ {rc, 24'h000000};
    n[0] = w[0] ^ t;
    for (int unsigned c = 1; c < 4; c++) begin
      n[c] = w[c] ^ n[c-1];
    end
    round_key_d = key_in;
    if (idx_in != 4'd0 && idx_in <= 4'd10) begin
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned c = 0; c < 4; c++) begin
          round_key_d[32*r+8*c +: 8] = n[c][31-8*r -: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_key_q <= '0;
    end else begin
      round_key_q <= round_key_d;
    end
  end

  assign roundKey = round_key_q;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion; S-box and Rcon are derived from GF(2^8) arithmetic.
module tb_key_expansion;

`ifdef KEYEXP_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [0:3]   keyInit;
  logic [0:127] key;
  logic [0:127] roundKey;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tb [256];
  logic [7:0] rcon_tb [10];

  localparam logic [0:127] K0  = 128'h2B28AB097EAEF7CF15D2154F16A6883C;
  localparam logic [0:127] K1  = 128'hA088232AFA54A36CFE2C397617B13905;
  localparam logic [0:127] K2  = 128'hF27A5973C296355995B980F6F2437A7F;
  localparam logic [0:127] K9  = 128'hAC19285777FAD15C66DC2900F321416E;
  localparam logic [0:127] K10 = 128'hD0C9E1B614EE3F63F9250C0CA889C8A6;

  key_expansion dut (
    .clk      (clk),
    .rst      (rst),
    .keyInit  (keyInit),
    .key      (key),
    .roundKey (roundKey)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int s);
    return (b << s) | (b >> (8 - s));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] r = 8'h01;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
      end
      sbox_tb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 10; i++) begin
      rcon_tb[i] = r;
      r = xtime(r);
    end
  endtask

  // Reference: one FIPS-197 key-schedule round on a row-major 4x4 byte matrix.
  function automatic logic [0:127] ref_round(input int idx, input logic [0:127] k);
    logic [7:0] w [4][4];
    logic [7:0] t [4];
    logic [0:127] r;
    if (idx < 1 || idx > 10) return k;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        w[c][row] = k[32*row+8*c +: 8];
    for (int i = 0; i < 4; i++) t[i] = sbox_tb[w[3][(i+1)%4]];
    t[0] = t[0] ^ rcon_tb[idx-1];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        w[c][row] = w[c][row] ^ ((c == 0) ? t[row] : w[c-1][row]);
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[32*row+8*c +: 8] = w[c][row];
    return r;
  endfunction

  task automatic drive_and_wait(input int idx, input logic [0:127] k);
    keyInit = idx[3:0];
    key     = k;
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [0:127] exp_v;
    rst = 1'b1;
    keyInit = 4'($urandom_range(1, 10));
    key = {$urandom, $urandom, $urandom, $urandom};
    #1;
    checks++;
    if (roundKey !== 128'h0) begin
      errors++; $display("FAIL reset_async got %h exp %h", roundKey, 128'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (roundKey !== 128'h0) begin
      errors++; $display("FAIL reset_hold got %h exp %h", roundKey, 128'h0);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (roundKey !== 128'h0) begin
      errors++; $display("FAIL reset_release got %h exp %h", roundKey, 128'h0);
    end
    exp_v = ref_round(int'(keyInit), key);
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if (roundKey !== exp_v) begin
      errors++; $display("FAIL reset_first_result got %h exp %h", roundKey, exp_v);
    end
  endtask

  task automatic test_model_vectors();
    checks++;
    if (ref_round(1, K0) !== K1) begin
      errors++; $display("FAIL model_round1 got %h exp %h", ref_round(1, K0), K1);
    end
    checks++;
    if (sbox_tb[8'h53] !== 8'hed) begin
      errors++; $display("FAIL model_sbox53 got %h exp %h", sbox_tb[8'h53], 8'hed);
    end
  endtask

  task automatic test_rounds();
    drive_and_wait(1, K0);
    checks++;
    if (roundKey !== K1) begin
      errors++; $display("FAIL round1 got %h exp %h", roundKey, K1);
    end
    drive_and_wait(2, K1);
    checks++;
    if (roundKey !== K2) begin
      errors++; $display("FAIL round2 got %h exp %h", roundKey, K2);
    end
    drive_and_wait(10, K9);
    checks++;
    if (roundKey !== K10) begin
      errors++; $display("FAIL round10 got %h exp %h", roundKey, K10);
    end
  endtask

  task automatic test_passthrough();
    int idxs [4] = '{0, 11, 12, 15};
    foreach (idxs[i]) begin
      drive_and_wait(idxs[i], K0);
      checks++;
      if (roundKey !== K0) begin
        errors++; $display("FAIL passthrough_idx%0d got %h exp %h", idxs[i], roundKey, K0);
      end
    end
  endtask

  task automatic test_chain_latency();
    logic [0:127] cur = K0;
    logic [0:127] exp_v;
    int cyc;
    @(posedge clk); #1;
    for (int r = 1; r <= 10; r++) begin
      exp_v = ref_round(r, cur);
      keyInit = r[3:0];
      key = cur;
      cyc = 0;
      while (cyc < 6 && roundKey !== exp_v) begin
        @(posedge clk); #1;
        cyc++;
      end
      checks++;
      if (cyc !== LAT) begin
        errors++; $display("FAIL chain_latency_r%0d got %0d exp %0d", r, cyc, LAT);
      end
      checks++;
      if (roundKey !== exp_v) begin
        errors++; $display("FAIL chain_r%0d got %h exp %h", r, roundKey, exp_v);
      end
      cur = roundKey;
      // Hold inputs so a pipelined build settles before the next index is applied.
      repeat (LAT - 1) @(posedge clk);
      #1;
    end
    checks++;
    if (cur !== K10) begin
      errors++; $display("FAIL chain_final got %h exp %h", cur, K10);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] exp_q [$];
    logic [0:127] exp_v;
    int n = 200;
    int idx;
    logic [0:127] k;
    @(posedge clk); #1;
    for (int i = 0; i < n + LAT; i++) begin
      if (i >= LAT) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (roundKey !== exp_v) begin
          errors++; $display("FAIL b2b_%0d got %h exp %h", i - LAT, roundKey, exp_v);
        end
      end
      if (i < n) begin
        idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 10);
        k = {$urandom, $urandom, $urandom, $urandom};
        keyInit = idx[3:0];
        key = k;
        exp_q.push_back(ref_round(idx, k));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [0:127] exp_v;
    drive_and_wait(3, K2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (roundKey !== 128'h0) begin
      errors++; $display("FAIL midreset_async got %h exp %h", roundKey, 128'h0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    keyInit = 4'd1;
    key = K0;
`ifdef KEYEXP_INREG_EN
    exp_v = 128'h0;
`else
    exp_v = K1;
`endif
    @(posedge clk); #1;
    checks++;
    if (roundKey !== exp_v) begin
      errors++; $display("FAIL midreset_first_edge got %h exp %h", roundKey, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1;
    keyInit = '0;
    key = '0;
    build_tables();
    test_reset();
    test_model_vectors();
    test_rounds();
    test_passthrough();
    test_chain_latency();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
